// File: rtl/eth_fcs_pkg.sv
// Shared types, CRC constants and helpers for the Ethernet FCS append stage.
package eth_fcs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_GAP
   } fcs_state_e;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   localparam int unsigned LEN_W = 11;

   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 advance by one octet; MSB-first register, octet bits taken in wire order (bit 0 first).
module eth_crc32_byte
   import eth_fcs_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next_c
);

   always_comb begin
      crc_next_c = crc;
      for (int i = 0; i < 8; i++) begin
         if (crc_next_c[31] ^ data[i]) begin
            crc_next_c = {crc_next_c[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            crc_next_c = {crc_next_c[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/eth_fcs_append.sv
// Ethernet TX framing: pass data, zero-pad to MIN_LEN, append FCS, then hold off for IFG_LEN cycles.
module eth_fcs_append
   import eth_fcs_pkg::*;
#(
   parameter int unsigned MIN_LEN = 60,
   parameter int unsigned IFG_LEN = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   output logic       busy
);

   localparam int unsigned          GAP_W    = $clog2(IFG_LEN + 2);
   localparam logic [LEN_W-1:0]     MIN_L    = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0]     LEN_MAX  = {LEN_W{1'b1}};
   localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((IFG_LEN == 0) ? 32'd0 : IFG_LEN - 1);

   fcs_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, len_inc_c;
   logic [31:0]      crc_q, crc_d, crc_in_c, crc_upd_c;
   logic [31:0]      fcs_sr_q, fcs_sr_d;
   logic [7:0]       byte_in_c, out_data_d;
   logic [1:0]       fcs_cnt_q, fcs_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             out_valid_d, out_last_d;

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DATA);
   assign len_inc_c = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

   // CRC engine operand select: seed on the first octet, zero octet while padding
   always_comb begin
      crc_in_c  = crc_q;
      byte_in_c = 8'h00;
      if (state_q == ST_IDLE) begin
         crc_in_c  = CRC_INIT;
         byte_in_c = in_data;
      end else if (state_q == ST_DATA && in_valid) begin
         byte_in_c = in_data;
      end
   end

   eth_crc32_byte u_crc (
      .crc        (crc_in_c),
      .data       (byte_in_c),
      .crc_next_c (crc_upd_c)
   );

   // Next-state and next-output; the octet loaded here is visible next cycle
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      crc_d       = crc_q;
      fcs_sr_d    = fcs_sr_q;
      fcs_cnt_d   = fcs_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      out_data_d  = 8'h00;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d     = ST_DATA;
               len_d       = LEN_W'(1);
               crc_d       = crc_upd_c;
               out_data_d  = in_data;
               out_valid_d = 1'b1;
            end
         end
         ST_DATA, ST_PAD: begin
            if (state_q == ST_DATA && in_valid) begin
               len_d       = len_inc_c;
               crc_d       = crc_upd_c;
               out_data_d  = in_data;
               out_valid_d = 1'b1;
            end else if (len_q < MIN_L) begin
               state_d     = ST_PAD;
               len_d       = len_inc_c;
               crc_d       = crc_upd_c;
               out_valid_d = 1'b1;
            end else begin
               // first FCS octet goes out straight from the complemented CRC
               state_d     = ST_FCS;
               fcs_sr_d    = ~crc_q;
               fcs_cnt_d   = 2'd0;
               out_data_d  = bitrev8(~crc_q[31:24]);
               out_valid_d = 1'b1;
            end
         end
         ST_FCS: begin
            fcs_cnt_d = fcs_cnt_q + 2'd1;
            fcs_sr_d  = {fcs_sr_q[23:0], fcs_sr_q[31:24]};
            if (fcs_cnt_q != 2'd3) begin
               out_data_d  = bitrev8(fcs_sr_q[23:16]);
               out_valid_d = 1'b1;
               out_last_d  = (fcs_cnt_q == 2'd2);
            end else begin
               gap_cnt_d = '0;
               if (IFG_LEN == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         crc_q     <= CRC_INIT;
         fcs_sr_q  <= '0;
         fcs_cnt_q <= '0;
         gap_cnt_q <= '0;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         crc_q     <= crc_d;
         fcs_sr_q  <= fcs_sr_d;
         fcs_cnt_q <= fcs_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         out_data  <= out_data_d;
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
         busy      <= (state_d != ST_IDLE);
      end
   end

endmodule
